// File: rtl/game_input_pkg.sv
// Shared types and constants for the game input conditioner.
//   - db_state_e : debounce FSM states
//   - phase_e    : auto-repeat phase of a step generator
//   - *_50M      : default cycle counts for a 50 MHz clock
//   - cnt_width  : counter width for a count of n cycles (never below 1 bit)
package game_input_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_e;

    typedef enum logic {
        DELAY = 1'b0,
        RATE  = 1'b1
    } phase_e;

    localparam int unsigned DB_CYCLES_50M        = 500000;    // 10 ms
    localparam int unsigned RPT_DELAY_CYCLES_50M = 15000000;  // 300 ms
    localparam int unsigned RPT_RATE_CYCLES_50M  = 2500000;   // 50 ms

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, debounce FSM and rise strobe for one push-button.
// Ports:
//   clk_50m  in   system clock
//   rst      in   synchronous reset, active-low
//   raw_i    in   raw button, active-high, asynchronous
//   level_o  out  debounced level
//   rise_o   out  one-cycle strobe in the first cycle level_o is high
//
// state        | meaning
// IDLE         | released, waiting for s=1
// PRESS_WAIT   | s=1 seen, counting stable high samples
// PRESSED      | accepted press, waiting for s=0
// RELEASE_WAIT | s=0 seen, counting stable low samples
module btn_debounce
    import game_input_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_50M
) (
    input  logic clk_50m,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned     CW       = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    db_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic          db_q;
    logic          db_dly_q;

    always_ff @(posedge clk_50m) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            db_dly_q <= db_q;
            case (state_q)
                IDLE: begin
                    if (sync2_q) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2_q) begin
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= PRESSED;
                        db_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!sync2_q) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync2_q) begin
                        state_q <= PRESSED;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                        db_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    db_q    <= 1'b0;
                end
            endcase
        end
    end

    assign level_o = db_q;
    assign rise_o  = db_q & ~db_dly_q;

endmodule

// File: rtl/game_input_conditioner.sv
// Player-control front end for the 100-floors game: debounces left, right
// and pause buttons, generates left/right step strobes (with optional
// auto-repeat) and a toggled pause level.
// Build option: define GIC_AUTO_REPEAT_EN for auto-repeat of held direction
// buttons; without it each accepted press gives exactly one strobe.
// Ports:
//   clk_50m        in   system clock, 50 MHz
//   rst            in   synchronous reset, active-low
//   btn_left_raw   in   raw left button, asynchronous
//   btn_right_raw  in   raw right button, asynchronous
//   btn_pause_raw  in   raw pause button, asynchronous
//   endgame        in   game-over flag
//   left_shift     out  one-cycle left step strobe
//   right_shift    out  one-cycle right step strobe
//   left_level     out  debounced left level
//   right_level    out  debounced right level
//   pause          out  high while paused
module game_input_conditioner
    import game_input_pkg::*;
#(
    parameter int unsigned DB_CYCLES        = DB_CYCLES_50M,
    parameter int unsigned RPT_DELAY_CYCLES = RPT_DELAY_CYCLES_50M,
    parameter int unsigned RPT_RATE_CYCLES  = RPT_RATE_CYCLES_50M
) (
    input  logic clk_50m,
    input  logic rst,
    input  logic btn_left_raw,
    input  logic btn_right_raw,
    input  logic btn_pause_raw,
    input  logic endgame,
    output logic left_shift,
    output logic right_shift,
    output logic left_level,
    output logic right_level,
    output logic pause
);

    // index 0 = left, 1 = right
    logic [1:0] db;
    logic [1:0] rise;
    logic [1:0] active;
    logic [1:0] fire;
    logic [1:0] armed_q, armed_d;
    logic       pause_lvl, pause_rise;
    logic       pause_q, pause_d;
    logic       suppress;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_left (
        .clk_50m (clk_50m), .rst(rst), .raw_i(btn_left_raw),
        .level_o (db[0]), .rise_o(rise[0])
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_right (
        .clk_50m (clk_50m), .rst(rst), .raw_i(btn_right_raw),
        .level_o (db[1]), .rise_o(rise[1])
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
        .clk_50m (clk_50m), .rst(rst), .raw_i(btn_pause_raw),
        .level_o (pause_lvl), .rise_o(pause_rise)
    );

    assign suppress = pause_q | endgame;

    // A direction may only step when armed; arming needs a release seen
    // outside pause, so a button held across a pause stays silent.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            armed_d[i] = armed_q[i];
            if (pause_q)
                armed_d[i] = 1'b0;
            else if (!db[i])
                armed_d[i] = 1'b1;
        end
    end

    // Both directions held cancels each other out.
    assign active = db & armed_q & {2{~suppress & ~(&db)}};

    always_comb begin
        pause_d = pause_q;
        if (endgame)
            pause_d = 1'b0;
        else if (pause_rise && pause_lvl)
            pause_d = ~pause_q;
    end

`ifdef GIC_AUTO_REPEAT_EN
    localparam int unsigned   RW         = cnt_width(RPT_DELAY_CYCLES);
    localparam logic [RW-1:0] DELAY_LAST = RW'(RPT_DELAY_CYCLES - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(RPT_RATE_CYCLES - 1);

    phase_e [1:0]          phase_q, phase_d;
    logic   [1:0][RW-1:0]  rc_q, rc_d;
    logic   [1:0]          active_q;

    // The first active cycle (fresh press, or partner released) restarts
    // the delay with rc=0; only a genuine rise strobes in that cycle.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            phase_d[i] = DELAY;
            rc_d[i]    = '0;
            fire[i]    = 1'b0;
            if (active[i]) begin
                if (!active_q[i]) begin
                    fire[i] = rise[i];
                end else if (phase_q[i] == DELAY && rc_q[i] == DELAY_LAST) begin
                    fire[i]    = 1'b1;
                    phase_d[i] = RATE;
                end else if (phase_q[i] == RATE && rc_q[i] == RATE_LAST) begin
                    fire[i]    = 1'b1;
                    phase_d[i] = RATE;
                end else begin
                    phase_d[i] = phase_q[i];
                    rc_d[i]    = rc_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_50m) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                phase_q[i] <= DELAY;
                rc_q[i]    <= '0;
            end
            active_q <= '0;
        end else begin
            phase_q  <= phase_d;
            rc_q     <= rc_d;
            active_q <= active;
        end
    end
`else
    assign fire = active & rise;
`endif

    always_ff @(posedge clk_50m) begin
        if (!rst) begin
            armed_q <= '0;
            pause_q <= 1'b0;
        end else begin
            armed_q <= armed_d;
            pause_q <= pause_d;
        end
    end

    assign left_shift  = fire[0];
    assign right_shift = fire[1];
    assign left_level  = db[0];
    assign right_level = db[1];
    assign pause       = pause_q;

endmodule

// File: tb/tb_game_input_conditioner.sv
module tb_game_input_conditioner;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 5;

    localparam logic [4:0] EV_LS = 5'b00001;
    localparam logic [4:0] EV_RS = 5'b00010;
    localparam logic [4:0] EV_LL = 5'b00100;
    localparam logic [4:0] EV_RL = 5'b01000;
    localparam logic [4:0] EV_P  = 5'b10000;

    logic clk_50m = 1'b0;
    logic rst = 1'b0;
    logic btn_left_raw = 1'b0;
    logic btn_right_raw = 1'b0;
    logic btn_pause_raw = 1'b0;
    logic endgame = 1'b0;
    logic left_shift, right_shift, left_level, right_level, pause;

    game_input_conditioner #(
        .DB_CYCLES(DB), .RPT_DELAY_CYCLES(RD), .RPT_RATE_CYCLES(RR)
    ) dut (
        .clk_50m(clk_50m), .rst(rst),
        .btn_left_raw(btn_left_raw), .btn_right_raw(btn_right_raw),
        .btn_pause_raw(btn_pause_raw), .endgame(endgame),
        .left_shift(left_shift), .right_shift(right_shift),
        .left_level(left_level), .right_level(right_level), .pause(pause)
    );

    always #5 clk_50m = ~clk_50m;

    // cyc = number of the last rising edge
    int cyc = 0;
    always @(posedge clk_50m) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [4:0] ev;
    } exp_t;
    exp_t exp_q[$];

    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;

    // expected events: bit set = strobe high / level toggled, at edge c
    function automatic void exp_add(input int c, input logic [4:0] ev);
        int   pos = exp_q.size();
        exp_t e;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].c == c) begin
                exp_q[i].ev = exp_q[i].ev | ev;
                return;
            end
            if (exp_q[i].c > c) begin
                pos = i;
                break;
            end
        end
        e.c  = c;
        e.ev = ev;
        exp_q.insert(pos, e);
    endfunction

    function automatic void exp_press(input int dir, input int rise_e, input int fall_e,
                                      input bit strobe);
        logic [4:0] lvl = (dir == 0) ? EV_LL : EV_RL;
        logic [4:0] stb = (dir == 0) ? EV_LS : EV_RS;
        exp_add(rise_e, strobe ? (lvl | stb) : lvl);
        exp_add(fall_e, lvl);
    endfunction

    // repeat strobes after a (re)start at edge base, for edges before stop
    function automatic void exp_repeat(input int dir, input int base, input int stop);
        int lim = stop;
`ifndef GIC_AUTO_REPEAT_EN
        lim = 0;
`endif
        for (int c = base + RD; c < lim; c += RR)
            exp_add(c, (dir == 0) ? EV_LS : EV_RS);
    endfunction

    task automatic before_edge(input int n);
        while (cyc < n - 1) @(negedge clk_50m);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor / scoreboard
    initial begin
        logic       pl_l, pl_r, pl_p;
        logic [4:0] ev;
        exp_t       e;
        wait (mon_en);
        pl_l = left_level;
        pl_r = right_level;
        pl_p = pause;
        forever begin
            @(negedge clk_50m);
            ev = {pause != pl_p, right_level != pl_r, left_level != pl_l,
                  right_shift, left_shift};
            pl_l = left_level;
            pl_r = right_level;
            pl_p = pause;
            while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_event: edge %0d expected ev=%b, nothing seen",
                         exp_q[0].c, exp_q[0].ev);
                e = exp_q.pop_front();
            end
            if (ev != 5'b0) begin
                checks++;
                if (exp_q.size() == 0 || exp_q[0].c != cyc) begin
                    errors++;
                    $display("FAIL unexpected_event: edge %0d got ev=%b expected none", cyc, ev);
                end else begin
                    e = exp_q.pop_front();
                    if (e.ev != ev) begin
                        errors++;
                        $display("FAIL event_bits: edge %0d got ev=%b expected ev=%b",
                                 cyc, ev, e.ev);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset for edges 1 and 2
        before_edge(3);
        check1("reset_left_shift",  left_shift,  1'b0);
        check1("reset_right_shift", right_shift, 1'b0);
        check1("reset_left_level",  left_level,  1'b0);
        check1("reset_right_level", right_level, 1'b0);
        check1("reset_pause",       pause,       1'b0);
        rst    = 1'b1;
        mon_en = 1'b1;

        // 1: 3-cycle glitch is rejected
        before_edge(10); btn_left_raw = 1'b1;
        before_edge(13); btn_left_raw = 1'b0;
        before_edge(25);
        check1("glitch_left_level", left_level, 1'b0);

        // 2: held left, rise at 30+2+DB, release 6 cycles after raw falls
        exp_press(0, 36, 96, 1'b1);
        exp_repeat(0, 36, 96);
        before_edge(30); btn_left_raw = 1'b1;
        before_edge(90); btn_left_raw = 1'b0;

        // 3: right pressed while left held, then released
        exp_press(0, 116, 226, 1'b1);
        exp_repeat(0, 116, 156);
        exp_press(1, 156, 186, 1'b0);
        exp_repeat(0, 186, 226);
        before_edge(110); btn_left_raw  = 1'b1;
        before_edge(150); btn_right_raw = 1'b1;
        before_edge(180); btn_right_raw = 1'b0;
        before_edge(220); btn_left_raw  = 1'b0;

        // 4: pause on/off with left held across the second press
        exp_press(0, 246, 306, 1'b1);
        exp_repeat(0, 246, 257);
        exp_add(257, EV_P);
        exp_add(287, EV_P);
        exp_press(0, 326, 346, 1'b1);
        exp_repeat(0, 326, 346);
        before_edge(240); btn_left_raw  = 1'b1;
        before_edge(250); btn_pause_raw = 1'b1;
        before_edge(260); btn_pause_raw = 1'b0;
        before_edge(270);
        check1("pause_on", pause, 1'b1);
        before_edge(280); btn_pause_raw = 1'b1;
        before_edge(290); btn_pause_raw = 1'b0;
        check1("pause_off", pause, 1'b0);
        before_edge(300); btn_left_raw  = 1'b0;
        before_edge(320); btn_left_raw  = 1'b1;
        before_edge(340); btn_left_raw  = 1'b0;

        // 5: endgame forces pause low and blocks pause and steps
        exp_add(367, EV_P);
        exp_add(380, EV_P);
        exp_press(0, 396, 416, 1'b0);
        before_edge(360); btn_pause_raw = 1'b1;
        before_edge(370); btn_pause_raw = 1'b0;
        before_edge(380); endgame = 1'b1;
        before_edge(390); btn_pause_raw = 1'b1; btn_left_raw = 1'b1;
        before_edge(400); btn_pause_raw = 1'b0;
        before_edge(410); btn_left_raw  = 1'b0;
        before_edge(420);
        check1("endgame_pause", pause, 1'b0);
        before_edge(430); endgame = 1'b0;

        // 6: reset while repeating; re-accept 6 cycles after rst releases
        exp_press(0, 446, 480, 1'b1);
        exp_repeat(0, 446, 480);
        exp_press(0, 487, 521, 1'b1);
        exp_repeat(0, 487, 521);
        before_edge(440); btn_left_raw = 1'b1;
        before_edge(480); rst = 1'b0;
        before_edge(481); rst = 1'b1;
        check1("midrst_left_shift",  left_shift,  1'b0);
        check1("midrst_right_shift", right_shift, 1'b0);
        check1("midrst_left_level",  left_level,  1'b0);
        check1("midrst_right_level", right_level, 1'b0);
        check1("midrst_pause",       pause,       1'b0);
        before_edge(515); btn_left_raw = 1'b0;

        // short right press
        exp_press(1, 546, 556, 1'b1);
        before_edge(540); btn_right_raw = 1'b1;
        before_edge(550); btn_right_raw = 1'b0;

        before_edge(600);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: %0d expected events never seen, want 0",
                     exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_input_conditioner.md
Name: game_input_conditioner

Overview:
- Upstream front-end for the player controls of the 100-floors game.
- Synchronises and debounces the raw left, right and pause push-buttons.
- Produces one-cycle step strobes for the horizontal-shift stage, plus a toggled pause level consumed by the shift, display and score stages.
- Auto-repeats the step strobes while a direction button is held, and freezes controls during pause and end-of-game.

Parameters:
- DB_CYCLES, 500000: consecutive stable samples required to accept a level change (10 ms at 50 MHz).
- RPT_DELAY_CYCLES, 15000000: hold time after an accepted press before the first auto-repeat strobe (300 ms).
- RPT_RATE_CYCLES, 2500000: spacing between auto-repeat strobes (50 ms).

Ports:
- clk_50m  in  1  system clock, 50 MHz
- rst  in  1  reset; synchronous, active-low
- btn_left_raw  in  1  raw left button, active-high, asynchronous to clk_50m
- btn_right_raw  in  1  raw right button, active-high, asynchronous
- btn_pause_raw  in  1  raw pause button, active-high, asynchronous
- endgame  in  1  game-over flag from the display stage, active-high
- left_shift  out  1  one-cycle left step strobe
- right_shift  out  1  one-cycle right step strobe
- left_level  out  1  debounced left button level
- right_level  out  1  debounced right button level
- pause  out  1  pause state, high = paused

Behaviour:
- Reset: rst low at a clk_50m edge clears the following on that edge: all outputs, synchroniser flops, debounce counters, repeat counters and FSMs.
- Synchroniser: each raw input passes through a 2-flop synchroniser; the value s is the second flop.
- Debounce FSM per button, with counter cnt of width clog2(DB_CYCLES):
  - IDLE: db=0. Move to PRESS_WAIT when s=1; cnt=0.
  - PRESS_WAIT: cnt increments while s=1; s=0 returns to IDLE. When cnt=DB_CYCLES-1 and s=1, go to PRESSED with db=1.
  - PRESSED: db=1. Move to RELEASE_WAIT when s=0.
  - RELEASE_WAIT: mirror of PRESS_WAIT; on completion go to IDLE with db=0. s=1 returns to PRESSED.
- Latency: raw rises before edge N and stays stable; db rises at edge N+2+DB_CYCLES.
- Glitches: any glitch shorter than DB_CYCLES produces no db change.
- left_level and right_level equal db for the respective button.
- Rise strobe: rise=db & ~db_q, one cycle.
- Step generator per direction, with counter rc of width clog2(RPT_DELAY_CYCLES):
  - On rise, the step strobe is asserted in the same cycle as db rises; rc=0, phase=DELAY.
  - DELAY: when rc=RPT_DELAY_CYCLES-1, strobe and set phase=RATE, rc=0.
  - RATE: strobe every RPT_RATE_CYCLES cycles while db=1.
  - db=0 clears rc and phase.
- Both directions held: while left_level&right_level, both strobes are forced 0 and both repeat counters hold at 0. Releasing one button restarts its partner at phase DELAY; no immediate strobe is issued.
- Pause toggle:
  - A debounced pause rise with endgame=0 toggles pause on the next edge.
  - When endgame=1, pause is forced 0 and pause rises are ignored.
- Suppression: while pause=1 or endgame=1, left_shift and right_shift are 0 and the repeat counters hold at 0. Debounce FSMs keep running, so left_level and right_level stay valid.
- Resume: a button still held when pause clears produces no strobe until it is released and pressed again. This is enforced by a per-direction armed flag cleared on pause and set when db=0.
- Reset mid-press: the FSMs return to IDLE. A button held through reset is accepted again after 2+DB_CYCLES cycles.

Optional Feature:
- Macro: GIC_AUTO_REPEAT_EN.
- Defined: auto-repeat as described above.
- Undefined:
  - Exactly one strobe per accepted press.
  - Repeat counters and RPT_* parameters are unused and their logic is removed.
  - All other behaviour is identical.

Decomposition:
- Shared package game_input_pkg holds:
  - debounce FSM state enum (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT);
  - repeat phase enum (DELAY, RATE);
  - default cycle constants for 50 MHz.
- Sub-module btn_debounce: synchroniser + debounce FSM + rise strobe, instantiated three times.
- The step/repeat logic and pause toggle live in the top.

Test Plan:
All tests use DB_CYCLES=4, RPT_DELAY_CYCLES=20, RPT_RATE_CYCLES=5.
1. btn_left_raw high for 3 cycles, then low -> left_level stays 0 and there are no left_shift strobes.
2. btn_left_raw rises before edge 10 and is held for 60 cycles -> left_level rises at edge 16 with a left_shift strobe at edge 16; repeat strobes at edges 36, 41, 46, ...; release stops strobes and left_level falls DB_CYCLES+2 cycles after release.
3. Left held, then right pressed while left held -> both strobes cease while both levels are 1; releasing right resumes left strobes only after a further RPT_DELAY_CYCLES.
4. Two debounced pause presses, with left held across the second -> pause goes 0→1→0; no left_shift while paused and none after resume until left is released and re-pressed.
5. endgame=1 with pause=1, then pause pressed -> pause forced 0, the pause press is ignored, no step strobes.
6. rst low for 1 cycle while left held with repeat active -> all outputs 0 on the next edge; left re-accepted 6 cycles after rst returns high; build without GIC_AUTO_REPEAT_EN gives a single strobe in test 2.
